axis_dwidth_downsize: RTL

- AXI-Stream width down-converter; the stage directly downstream of the team's upsizer.
- Accepts one wide word of WIDTH*NUM_REG bits and emits NUM_REG narrow beats of WIDTH bits, lane 0 first.
- Supports per-lane keep so a short final word emits fewer beats, and propagates tlast onto the final emitted narrow beat.
- Single buffered word; full throughput when the sink is always ready.

---
 rtl/axis_dwidth_downsize.sv | 82 ++++++++
 1 files changed

// File: rtl/axis_dwidth_downsize.sv
// AXI-Stream width down-converter: one WIDTH*NUM_REG word in, up to NUM_REG
// WIDTH-bit beats out (lane 0 first), trimmed by keep, tlast on the final beat.
module axis_dwidth_downsize #(
   parameter int WIDTH   = 32,
   parameter int NUM_REG = 2
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [WIDTH*NUM_REG-1:0] s_axis_tdata,
   input  logic [NUM_REG-1:0]       s_axis_tkeep,
   input  logic                     s_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [WIDTH-1:0]         m_axis_tdata,
   output logic                     m_axis_tlast
);
   localparam int IW = (NUM_REG > 2) ? $clog2(NUM_REG) : 1;

   typedef enum logic {EMPTY, SEND} state_t;

   state_t                           state, state_nxt;
   logic [NUM_REG-1:0][WIDTH-1:0]    wbuf;
   logic [NUM_REG-1:0]               kbuf;
   logic                             lbuf;
   logic [IW-1:0]                    idx;
   logic [IW-1:0]                    lst;
   logic                             final_beat;
   logic                             accept;
   logic                             load;
   logic                             adv;

   // Index of the highest kept lane (nbeats-1); lanes below it go out even if
   // their keep bit is clear.
   function automatic logic [IW-1:0] hi_lane(input logic [NUM_REG-1:0] k);
      hi_lane = '0;
      for (int i = 0; i < NUM_REG; i++)
         if (k[i]) hi_lane = IW'(i);
   endfunction

   assign lst           = hi_lane(kbuf);
   assign final_beat    = (state == SEND) && (idx == lst);
   assign s_axis_tready = aresetn && ((state == EMPTY) || (final_beat && m_axis_tready));
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign load          = accept && (|s_axis_tkeep);
   assign adv           = (state == SEND) && m_axis_tready && !final_beat;

   assign m_axis_tvalid = (state == SEND);
   assign m_axis_tdata  = wbuf[idx];
   assign m_axis_tlast  = final_beat && lbuf;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (load) state_nxt = SEND;
         SEND:  if (final_beat && m_axis_tready) state_nxt = load ? SEND : EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= EMPTY;
         wbuf  <= '0;
         kbuf  <= '0;
         lbuf  <= 1'b0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         // A zero-keep word is consumed without touching the buffer.
         if (load) begin
            wbuf <= s_axis_tdata;
            kbuf <= s_axis_tkeep;
            lbuf <= s_axis_tlast;
            idx  <= '0;
         end else if (adv) begin
            idx <= idx + IW'(1);
         end
      end
   end
endmodule
